// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_ADC = 3'b010,
      OP_SBC = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the processor control FSM (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 8) ();

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] first;
   logic [WIDTH-1:0] second;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             z;
   logic             s;
   logic             v;
   logic             c;

   modport master (
      output start, op, first, second,
      input  busy, done, result, result_hi, z, s, v, c
   );

   modport slave (
      input  start, op, first, second,
      output busy, done, result, result_hi, z, s, v, c
   );

endinterface

// File: rtl/alu_seq_mul_shift_add.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per cycle.
// product_o shows the accumulator after the step taken this cycle, so on the
// cycle last_o is high it already holds the complete product.
module mul_shift_add #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   product_o,
   output logic                 last_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               active_q, active_d;
   logic [2*WIDTH-1:0] acc_step;

   // Accumulator value after conditionally adding the shifted multiplicand.
   always_comb begin
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

   // Load operands, then step once per cycle while the down-counter runs out.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         cnt_d    = CW'(WIDTH);
         active_d = 1'b1;
      end else if (active_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            active_d = 1'b0;
         end
      end
   end

   // Multiplier state registers; reset abandons any product in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign product_o = acc_step;
   assign last_o    = active_q && (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with carry-chained add/sub, bitwise ops and an optional
// iterative signed multiply. Results and flags only change on completion.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; single-cycle ops complete here
//   ST_MUL   | iterative multiply running, busy=1, start ignored
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   logic [WIDTH-1:0]   a, b;
   op_e                op;

   state_e             state_q, state_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               z_q, z_d;
   logic               s_q, s_d;
   logic               v_q, v_d;
   logic               c_q, c_d;
   logic               neg_q, neg_d;

   logic               cin;
   logic [WIDTH:0]     add_ext;
   logic [WIDTH:0]     sub_ext;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] prod_s;
   logic               mul_load;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_last;

   assign a  = bus.first;
   assign b  = bus.second;
   assign op = op_e'(bus.op);

   // Magnitudes feed the unsigned multiplier; the most negative value maps to 2^(WIDTH-1).
   assign abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
   assign abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

   generate
      if (MUL_EN != 0) begin : g_mul
         mul_shift_add #(.WIDTH(WIDTH)) u_mul (
            .clk       (clk),
            .rst       (rst),
            .load_i    (mul_load),
            .a_i       (abs_a),
            .b_i       (abs_b),
            .product_o (mul_prod),
            .last_o    (mul_last)
         );
      end else begin : g_no_mul
         assign mul_prod = '0;
         assign mul_last = 1'b0;
      end
   endgenerate

   // State register plus all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         done_q      <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         z_q         <= 1'b0;
         s_q         <= 1'b0;
         v_q         <= 1'b0;
         c_q         <= 1'b0;
         neg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         z_q         <= z_d;
         s_q         <= s_d;
         v_q         <= v_d;
         c_q         <= c_d;
         neg_q       <= neg_d;
      end
   end

   // Next state: only an accepted MUL leaves IDLE; the multiplier's last step returns.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && (op == OP_MUL) && (MUL_EN != 0)) begin
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (mul_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and flag updates; everything holds unless an op completes.
   always_comb begin
      result_d    = result_q;
      result_hi_d = result_hi_q;
      z_d         = z_q;
      s_d         = s_q;
      v_d         = v_q;
      c_d         = c_q;
      neg_d       = neg_q;
      done_d      = 1'b0;
      mul_load    = 1'b0;

      cin     = c_q & ((op == OP_ADC) || (op == OP_SBC));
      add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      prod_s  = neg_q ? (~mul_prod + (2*WIDTH)'(1)) : mul_prod;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               done_d      = 1'b1;
               result_hi_d = '0;
               unique case (op)
                  OP_ADD, OP_ADC: begin
                     result_d = add_ext[WIDTH-1:0];
                     c_d      = add_ext[WIDTH];
                     v_d      = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_SUB, OP_SBC: begin
                     result_d = sub_ext[WIDTH-1:0];
                     c_d      = sub_ext[WIDTH];
                     v_d      = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_AND: begin
                     result_d = a & b;
                     v_d      = 1'b0;
                  end
                  OP_OR: begin
                     result_d = a | b;
                     v_d      = 1'b0;
                  end
                  OP_XOR: begin
                     result_d = a ^ b;
                     v_d      = 1'b0;
                  end
                  OP_MUL: begin
                     if (MUL_EN != 0) begin
                        done_d      = 1'b0;
                        result_hi_d = result_hi_q;
                        mul_load    = 1'b1;
                        neg_d       = a[WIDTH-1] ^ b[WIDTH-1];
                     end else begin
                        result_d = '0;
                        v_d      = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (mul_last) begin
               done_d      = 1'b1;
               result_d    = prod_s[WIDTH-1:0];
               result_hi_d = prod_s[2*WIDTH-1:WIDTH];
               // Fits in WIDTH signed bits only if the upper WIDTH+1 bits are a pure sign extension.
               v_d         = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
            end
         end
         default: ;
      endcase

      if (done_d) begin
         z_d = ~(|result_d);
         s_d = result_d[WIDTH-1];
      end
   end

   assign bus.busy      = (state_q == ST_MUL);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.z         = z_q;
   assign bus.s         = s_q;
   assign bus.v         = v_q;
   assign bus.c         = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic       m_c = 1'b0;
   logic [7:0] m_res, m_hi;
   logic       m_z, m_s, m_v;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer arithmetic, then truncate and derive flags.
   task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int sa, sb, ua, ub, cin, ex, ue;
      longint p;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      ua  = int'(a);
      ub  = int'(b);
      cin = ((op == 3'd2) || (op == 3'd3)) ? int'(m_c) : 0;
      m_hi = 8'h00;
      case (op)
         3'd0, 3'd2: begin
            ex    = sa + sb + cin;
            ue    = ua + ub + cin;
            m_res = 8'(ue);
            m_c   = (ue > 255);
            m_v   = (ex > 127) || (ex < -128);
         end
         3'd1, 3'd3: begin
            ex    = sa - sb - cin;
            ue    = ua - ub - cin;
            m_res = 8'(ue);
            m_c   = (ua < ub + cin);
            m_v   = (ex > 127) || (ex < -128);
         end
         3'd4: begin m_res = a & b; m_v = 1'b0; end
         3'd5: begin m_res = a | b; m_v = 1'b0; end
         3'd6: begin m_res = a ^ b; m_v = 1'b0; end
         default: begin
            p     = longint'(sa) * longint'(sb);
            m_res = 8'(p);
            m_hi  = 8'(p >>> 8);
            m_v   = (p > 127) || (p < -128);
         end
      endcase
      m_z = (m_res == 8'h00);
      m_s = m_res[7];
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " result"},    32'(bus.result),    32'(m_res));
      check({tag, " result_hi"}, 32'(bus.result_hi), 32'(m_hi));
      check({tag, " z"},         32'(bus.z),         32'(m_z));
      check({tag, " s"},         32'(bus.s),         32'(m_s));
      check({tag, " v"},         32'(bus.v),         32'(m_v));
      check({tag, " c"},         32'(bus.c),         32'(m_c));
   endtask

   // One op with random don't-care starts while busy; checks busy, latency, outputs, pulse width.
   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
      int cyc;
      bit is_mul;
      is_mul = (op == 3'd7);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.first  = a;
      bus.second = b;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op     = 3'($urandom);
      bus.first  = 8'($urandom);
      bus.second = 8'($urandom);
      cyc = 0;
      while ((bus.done !== 1'b1) && (cyc < 40)) begin
         check({tag, " busy"}, 32'(bus.busy), 32'(is_mul));
         if (is_mul) bus.start = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 32'(cyc), is_mul ? 32'(W) : 32'd0);
      check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
      model(op, a, b);
      check_outputs(tag);
      @(negedge clk);
      check({tag, " done pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int cyc;
      bit saw_done;

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.first  = 8'h00;
      bus.second = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_c = 1'b0; m_res = 8'h00; m_hi = 8'h00; m_z = 1'b0; m_s = 1'b0; m_v = 1'b0;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check_outputs("reset");

      run_op(3'd0, 8'd100, 8'd50, "add 100+50");
      check("add 100+50 const", 32'(bus.result), 32'h96);
      run_op(3'd1, 8'h80, 8'h01, "sub 80-01");
      check("sub 80-01 const v", 32'(bus.v), 32'd1);
      run_op(3'd1, 8'h01, 8'h02, "sub 01-02");
      check("sub 01-02 const c", 32'(bus.c), 32'd1);
      run_op(3'd0, 8'hFF, 8'h01, "add ff+01");
      run_op(3'd2, 8'h00, 8'h00, "adc 0+0+c");
      check("adc const", 32'(bus.result), 32'h01);
      run_op(3'd7, 8'hFD, 8'h07, "mul -3x7");
      check("mul -3x7 const", {16'h0, bus.result_hi, bus.result}, 32'hFFEB);
      run_op(3'd7, 8'h80, 8'h80, "mul 80x80");
      check("mul 80x80 const", {16'h0, bus.result_hi, bus.result}, 32'h4000);
      run_op(3'd3, 8'h10, 8'h20, "sbc 10-20");
      run_op(3'd3, 8'h10, 8'h05, "sbc 10-05-c");

      // ADD start pulsed mid-MUL must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd7; bus.first = 8'd16; bus.second = 8'd16;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.first = 8'd1; bus.second = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while ((bus.done !== 1'b1) && (cyc < 40)) begin
         @(negedge clk);
         cyc++;
      end
      check("ignored start latency", 32'(cyc), 32'd6);
      model(3'd7, 8'd16, 8'd16);
      check_outputs("mul 16x16 ignore");
      check("mul 16x16 const", {16'h0, bus.result_hi, bus.result}, 32'h0100);
      @(negedge clk);
      check("ignored start no done", 32'(bus.done), 32'd0);

      // Reset during MUL abandons it without a done pulse.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd7; bus.first = 8'd16; bus.second = 8'd16;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_c = 1'b0; m_res = 8'h00; m_hi = 8'h00; m_z = 1'b0; m_s = 1'b0; m_v = 1'b0;
      check("midmul reset busy", 32'(bus.busy), 32'd0);
      check("midmul reset done", 32'(bus.done), 32'd0);
      check_outputs("midmul reset");
      saw_done = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("midmul reset no done", 32'(saw_done), 32'd0);
      run_op(3'd0, 8'd1, 8'd1, "add 1+1");
      check("add 1+1 const", 32'(bus.result), 32'h02);

      // Back-to-back: new start in the done cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.first = 8'd5; bus.second = 8'd5;
      @(negedge clk);
      check("b2b first done", 32'(bus.done), 32'd1);
      model(3'd0, 8'd5, 8'd5);
      check_outputs("b2b add");
      bus.op = 3'd6; bus.first = 8'hF0; bus.second = 8'h0F;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b second done", 32'(bus.done), 32'd1);
      model(3'd6, 8'hF0, 8'h0F);
      check_outputs("b2b xor");
      check("b2b xor const", 32'(bus.result), 32'hFF);
      @(negedge clk);
      check("b2b done drop", 32'(bus.done), 32'd0);

      // Randomized ops against the reference model.
      for (int i = 0; i < 80; i++) begin
         run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's 8-bit add/sub ALU.
- Adds:
  - configurable WIDTH
  - carry-in ops (ADC/SBC) with a stored carry flag
  - bitwise ops
  - a multi-cycle iterative signed multiply
- Start/busy/done handshake to the processor control FSM; result and Z/S/V/C flags are registered and update only on completion.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4); operands are two's complement.
- MUL_EN, 1, 1 = include iterative multiplier; 0 = op MUL is a single-cycle no-op (see Behaviour).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  3  operation code, sampled with start.
- first  in  WIDTH  operand A, sampled with start.
- second  in  WIDTH  operand B, sampled with start.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse; result/flags valid and updated.
- result  out  WIDTH  low WIDTH bits of the result.
- result_hi  out  WIDTH  high WIDTH bits of the MUL product; 0 for all other ops.
- z  out  1  zero flag.
- s  out  1  sign flag.
- v  out  1  signed-overflow flag.
- c  out  1  carry/borrow flag.

Behaviour:
- Reset: on rst=1 at a clk edge, the next cycle has busy=0, done=0, result=0, result_hi=0, z=0, s=0, v=0, c=0, state=IDLE. This applies mid-operation: an in-flight MUL is abandoned and done is not asserted.
- Op encoding:
  - 000 ADD, 001 SUB, 010 ADC, 011 SBC
  - 100 AND, 101 OR, 110 XOR, 111 MUL
- FSM states: IDLE, MUL.
  - IDLE + start + non-MUL op: compute on the sampled operands; result/flags registered at the edge; done=1 in the next cycle; stay in IDLE; busy never rises.
  - IDLE + start + MUL (MUL_EN=1): latch |first|, |second| and the product sign; go to MUL; busy=1.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the last step, apply the sign (two's-complement negate of the 2*WIDTH product if the signs differ), register result/result_hi/flags, return to IDLE, busy=0, done=1 next cycle.
- MUL latency: start accepted at edge N → busy=1 during cycles N+1..N+WIDTH, done=1 in cycle N+WIDTH+1.
- start while busy=1 is ignored; first, second and op are don't-care.
- start in the cycle where done=1 is accepted, so back-to-back ops are allowed.
- done is high for exactly one cycle per accepted start.
- Outputs hold their values between operations.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD: A+B; c = unsigned carry-out.
  - SUB: A-B; c = borrow (unsigned A < unsigned B).
  - ADC: A+B+c; c updates as for ADD.
  - SBC: A-B-c; c updates as for SUB.
  - ADD/SUB/ADC/SBC: v=1 iff the exact signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - AND/OR/XOR: v=0, c unchanged.
  - MUL: product is 2*WIDTH-bit signed, {result_hi, result}. v=1 iff the product does not fit in WIDTH signed bits. c unchanged. -2^(WIDTH-1) operands are handled via WIDTH-bit unsigned magnitude.
- z = (result==0), low WIDTH bits only, for all ops.
- s = result[WIDTH-1] for all ops.
- MUL_EN=0: op 111 behaves as a single-cycle op with result=0, result_hi=0, z=1, s=0, v=0, c unchanged.

Decomposition:
- Package alu_pkg holds:
  - the op code constants (OP_ADD..OP_MUL)
  - the FSM state encoding (ST_IDLE, ST_MUL)
- Sub-module mul_shift_add: unsigned WIDTH×WIDTH iterative multiplier.
  - Inputs: load, a, b.
  - Outputs: 2*WIDTH product, last-step strobe.
  - Generated only when MUL_EN=1.
  - alu_seq owns sign handling and flags.

Test Plan:
- WIDTH=8, ADD 100+50 at edge N → cycle N+1: done=1, result=0x96, s=1, v=1, z=0, c=0, busy stayed 0.
- SUB 0x80-0x01 → result 0x7F, v=1, s=0, c=0. Then SUB 0x01-0x02 → result 0xFF, c=1, v=0.
- ADD 0xFF+0x01 → result 0x00, z=1, c=1. Next op ADC 0x00+0x00 → result 0x01, c=0, z=0.
- MUL -3×7 (0xFD, 0x07) at edge N:
  - busy=1 in cycles N+1..N+8.
  - cycle N+9: done=1, result_hi=0xFF, result=0xEB, v=0, s=1.
  - MUL 0x80×0x80 → result_hi=0x40, result=0x00, z=1, v=1.
- MUL 16×16 in flight with start pulsed (ADD) at N+3 → the start is ignored and the MUL completes with result_hi=0x01, result=0x00, v=1.
  - Repeat with rst=1 at N+4 → next cycle all outputs 0, busy=0, no done.
  - Then ADD 1+1 → result 0x02, done at the next cycle.
- Back-to-back: ADD 5+5, with start (XOR 0xF0^0x0F) asserted in the cycle done=1 → done on two consecutive cycles with results 0x0A then 0xFF; c unchanged by XOR.
